// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the core's memory-port arbitration.
// Imported by the arbiter and by anything that needs to decode its state or owner.
package riscv_mem_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_D  = 2'd2,
    RESP     = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the load/store path.
// Data wins by default; fetch is served after at most STARVE_MAX back-to-back data grants.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter  int ADDR_W     = DEF_ADDR_W,
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int STARVE_MAX = 2,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t state;
  owner_t     owner;
  logic [3:0] streak;

  logic       grant_d;
  logic       grant_if;
  logic [3:0] streak_nxt;

  // Arbitration is only evaluated in IDLE; both requests resolve in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    grant_d    = 1'b0;
    grant_if   = 1'b0;
    streak_nxt = streak;
    if (state == IDLE) begin
      if (d_req && (!if_req || (streak < STARVE_LIM))) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end

      if (grant_d && if_req) begin
        streak_nxt = (streak == 4'hF) ? streak : streak + 4'd1;
      end else if (grant_d || grant_if) begin
        streak_nxt = 4'd0;
      end
    end
  end

  assign if_stall = if_req && !if_ack;
  assign d_stall  = d_req && !d_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      streak    <= 4'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
      if_ack <= 1'b0;
      d_ack  <= 1'b0;

      unique case (state)
        IDLE: begin
          streak <= streak_nxt;
          if (grant_d) begin
            state     <= GRANT_D;
            owner     <= OWN_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
          end else if (grant_if) begin
            state     <= GRANT_IF;
            owner     <= OWN_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
          end
        end

        GRANT_IF, GRANT_D: begin
          // Memory may stall indefinitely; mem_* fields stay frozen until it answers.
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (owner == OWN_IF) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
              d_ack <= 1'b1;
            end
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a timestamp-based transaction model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int STARVE_MAX = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, if_ack, if_stall;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we, d_ack, d_stall;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [BE_W-1:0]   d_be;
  logic              mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [BE_W-1:0]   mem_be;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- requester agents and memory ----------------
  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } d_tx_t;

  logic [ADDR_W-1:0] if_q[$];
  d_tx_t             d_q[$];
  logic [DATA_W-1:0] mem_img [512];
  int                ws;
  int                gcnt;

  initial begin : drv
    forever begin
      @(posedge clk); #2;
      if (if_req && if_ack) begin if_q.delete(0); if_req = 1'b0; end
      if (d_req && d_ack)   begin d_q.delete(0);  d_req  = 1'b0; end
      if (!if_req && if_q.size() > 0) begin if_req = 1'b1; if_addr = if_q[0]; end
      if (!d_req && d_q.size() > 0) begin
        d_req = 1'b1; d_we = d_q[0].we; d_addr = d_q[0].addr;
        d_wdata = d_q[0].wdata; d_be = d_q[0].be;
      end
      // Memory answers after ws wait states of an asserted request.
      if (mem_req) begin
        mem_ready = (gcnt >= ws);
        gcnt++;
      end else begin
        mem_ready = 1'b0;
        gcnt = 0;
      end
      mem_rdata = mem_img[mem_addr];
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic              is_d;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } m_tx_t;

  int                m_cyc, m_next_free, m_ack_at, m_streak;
  bit                m_busy, m_ack_d;
  m_tx_t             m_tx;
  logic [DATA_W-1:0] e_if_rdata, e_d_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0; m_next_free <= 0; m_ack_at <= -1; m_streak <= 0;
      m_busy <= 1'b0; m_ack_d <= 1'b0;
      m_tx <= '{1'b0, 1'b0, '0, '0, '0};
      e_if_rdata <= '0; e_d_rdata <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_busy) begin
        if (mem_ready) begin
          m_busy      <= 1'b0;
          m_ack_at    <= m_cyc + 1;
          m_ack_d     <= m_tx.is_d;
          m_next_free <= m_cyc + 2;
          if (!m_tx.is_d) e_if_rdata <= mem_rdata;
          else if (!m_tx.we) e_d_rdata <= mem_rdata;
        end
      end else if (m_cyc >= m_next_free && (if_req || d_req)) begin
        m_busy <= 1'b1;
        if (d_req && (!if_req || m_streak < STARVE_MAX)) begin
          m_tx     <= '{1'b1, d_we, d_addr, d_wdata, d_be};
          m_streak <= if_req ? ((m_streak >= 15) ? 15 : m_streak + 1) : 0;
        end else begin
          m_tx     <= '{1'b0, 1'b0, if_addr, 32'h0, 4'hF};
          m_streak <= 0;
        end
      end
    end
  end

  bit run_cmp = 1'b0;

  always @(negedge clk) begin
    if (run_cmp) begin
      logic e_if_ack, e_d_ack;
      e_if_ack = (m_ack_at == m_cyc) && !m_ack_d;
      e_d_ack  = (m_ack_at == m_cyc) && m_ack_d;
      check("mem_req",   mem_req,   m_busy);
      check("mem_we",    mem_we,    m_tx.we);
      check("mem_addr",  mem_addr,  m_tx.addr);
      check("mem_wdata", mem_wdata, m_tx.wdata);
      check("mem_be",    mem_be,    m_tx.be);
      check("if_ack",    if_ack,    e_if_ack);
      check("d_ack",     d_ack,     e_d_ack);
      check("if_rdata",  if_rdata,  e_if_rdata);
      check("d_rdata",   d_rdata,   e_d_rdata);
      check("if_stall",  if_stall,  if_req && !e_if_ack);
      check("d_stall",   d_stall,   d_req && !e_d_ack);
    end
  end

  // Grant-order recorder for the starvation scenario.
  bit  rec_en = 1'b0;
  byte order[$];
  always @(negedge clk) begin
    if (rec_en && d_ack)  order.push_back(8'h44);
    if (rec_en && if_ack) order.push_back(8'h49);
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(if_q.size() == 0 && d_q.size() == 0 && !if_req && !d_req) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", n < budget, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    string exp_order;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_ready = 1'b0; mem_rdata = '0; ws = 0; gcnt = 0;
    for (int i = 0; i < 512; i++) mem_img[i] = 32'hA500_0000 | i;
    mem_img[9'h010] = 32'h0050_0093;

    // Reset with both requests pending: everything zero, D granted first.
    if_q.push_back(9'h011);
    d_q.push_back('{1'b0, 9'h033, 32'h0, 4'hF});
    repeat (3) @(posedge clk);
    run_cmp = 1'b1;
    @(negedge clk);
    check("rst_mem_req",  mem_req,  1'b0);
    check("rst_mem_addr", mem_addr, 9'h000);
    check("rst_mem_be",   mem_be,   4'h0);
    check("rst_if_ack",   if_ack,   1'b0);
    check("rst_d_ack",    d_ack,    1'b0);
    check("rst_d_rdata",  d_rdata,  32'h0);
    @(posedge clk); #3; rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("first_grant_req",  mem_req,  1'b1);
    check("first_grant_addr", mem_addr, 9'h033);
    check("first_grant_we",   mem_we,   1'b0);
    wait_idle(40);
    check("rst_if_rdata", if_rdata, 32'hA500_0011);

    // Zero-wait fetch.
    if_q.push_back(9'h010);
    @(negedge clk);
    check("zw_c0_mem_req", mem_req, 1'b0);
    @(negedge clk);
    check("zw_c1_mem_req",  mem_req,  1'b1);
    check("zw_c1_mem_addr", mem_addr, 9'h010);
    @(negedge clk);
    check("zw_c2_if_ack",   if_ack,   1'b1);
    check("zw_c2_if_rdata", if_rdata, 32'h0050_0093);
    check("zw_c2_mem_req",  mem_req,  1'b0);
    wait_idle(40);

    // Simultaneous store and fetch: store first, fetch three cycles later.
    d_q.push_back('{1'b1, 9'h020, 32'hDEAD_BEEF, 4'hF});
    if_q.push_back(9'h012);
    @(negedge clk);
    @(negedge clk);
    check("sim_c1_we",    mem_we,    1'b1);
    check("sim_c1_be",    mem_be,    4'hF);
    check("sim_c1_addr",  mem_addr,  9'h020);
    check("sim_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("sim_c2_d_ack", d_ack, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("sim_c4_addr", mem_addr, 9'h012);
    @(negedge clk);
    check("sim_c5_if_ack",  if_ack,  1'b1);
    check("sim_c5_d_rdata", d_rdata, 32'hA500_0033);
    wait_idle(40);

    // Load with three memory wait states.
    ws = 3;
    d_q.push_back('{1'b0, 9'h044, 32'h0, 4'hF});
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("ws_mem_req",  mem_req,  1'b1);
      check("ws_mem_addr", mem_addr, 9'h044);
    end
    @(negedge clk);
    check("ws_c5_d_ack",   d_ack,   1'b1);
    check("ws_c5_d_rdata", d_rdata, 32'hA500_0044);
    @(negedge clk);
    check("ws_c6_d_ack", d_ack, 1'b0);
    wait_idle(40);
    ws = 0;

    // Starvation bound with both sides continuously requesting.
    rec_en = 1'b1;
    d_q.push_back('{1'b0, 9'h050, 32'h0, 4'hF});
    d_q.push_back('{1'b1, 9'h051, 32'h1111_2222, 4'h3});
    d_q.push_back('{1'b0, 9'h052, 32'h0, 4'hF});
    d_q.push_back('{1'b1, 9'h053, 32'h3333_4444, 4'hC});
    if_q.push_back(9'h060);
    if_q.push_back(9'h061);
    wait_idle(80);
    rec_en = 1'b0;
    exp_order = "DDIDDI";
    check("order_len", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++) check("order", order[i], exp_order[i]);

    // Reset during GRANT_D: request abandoned, re-granted with refreshed fields.
    ws = 50;
    d_q.push_back('{1'b0, 9'h055, 32'h0, 4'hF});
    @(posedge clk);
    @(posedge clk); #3;
    check("rm_pre_mem_req", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rm_mem_req_drop", mem_req, 1'b0);
    check("rm_d_ack",        d_ack,   1'b0);
    d_addr = 9'h066;
    d_q[0].addr = 9'h066;
    ws = 0;
    repeat (2) begin
      @(negedge clk);
      check("rm_hold_d_ack", d_ack, 1'b0);
    end
    @(posedge clk); #3; rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rm_c1_mem_req",  mem_req,  1'b1);
    check("rm_c1_mem_addr", mem_addr, 9'h066);
    @(negedge clk);
    check("rm_c2_d_ack",   d_ack,   1'b1);
    check("rm_c2_d_rdata", d_rdata, 32'hA500_0066);
    wait_idle(40);

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
